// File: rtl/boundary_link_pkg.sv
// Shared definitions for the boundary-exchange transmit path: channel state
// encoding and the beats-per-field helper.
package boundary_link_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_STEP = 2'd1,
        SEND_X    = 2'd2,
        SEND_Y    = 2'd3
    } chan_state_t;

    function automatic int beats_per_field(input int field_w, input int link_w);
        return field_w / link_w;
    endfunction

endpackage

// File: rtl/boundary_tx_channel.sv
// One boundary channel: snapshots {step, x, y} on step_done and streams it
// LSB-first as a framed LINK_W-wide valid/ready sequence.
module boundary_tx_channel
    import boundary_link_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINK_W = 8,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_done,
    input  logic [STEP_W-1:0] step_idx,
    input  logic [DATA_W-1:0] pos_x,
    input  logic [DATA_W-1:0] pos_y,
    input  logic              ready,
    output logic              valid,
    output logic [LINK_W-1:0] data,
    output logic              last,
    output logic              active,
    output logic              ignored
);

    localparam int STEP_BEATS = beats_per_field(STEP_W, LINK_W);
    localparam int POS_BEATS  = beats_per_field(DATA_W, LINK_W);
    localparam int MAX_BEATS  = (POS_BEATS > STEP_BEATS) ? POS_BEATS : STEP_BEATS;
    localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    chan_state_t       state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [STEP_W-1:0] snap_step_r, snap_step_s;
    logic [DATA_W-1:0] snap_x_r, snap_x_s;
    logic [DATA_W-1:0] snap_y_r, snap_y_s;
    logic              valid_r, last_r, last_s;
    logic [LINK_W-1:0] data_r, beat_s;
    logic              xfer_s, final_s, accept_s;

    assign xfer_s   = valid_r & ready;
    assign final_s  = xfer_s & (state_r == SEND_Y) & (cnt_r == CNT_W'(POS_BEATS - 1));
    // A step_done landing on the closing handshake chains straight into a new frame.
    assign accept_s = step_done & ((state_r == IDLE) | final_s);
    assign ignored  = step_done & ~accept_s;
    assign active   = (state_r != IDLE);
    assign valid    = valid_r;
    assign data     = data_r;
    assign last     = last_r;

    // Next state, beat counter and snapshot capture.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        snap_step_s = snap_step_r;
        snap_x_s    = snap_x_r;
        snap_y_s    = snap_y_r;
        if (accept_s) begin
            state_s     = SEND_STEP;
            cnt_s       = '0;
            snap_step_s = step_idx;
            snap_x_s    = pos_x;
            snap_y_s    = pos_y;
        end else if (xfer_s) begin
            case (state_r)
                SEND_STEP: begin
                    if (cnt_r == CNT_W'(STEP_BEATS - 1)) begin
                        state_s = SEND_X;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                SEND_X: begin
                    if (cnt_r == CNT_W'(POS_BEATS - 1)) begin
                        state_s = SEND_Y;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                SEND_Y: begin
                    if (cnt_r == CNT_W'(POS_BEATS - 1)) begin
                        state_s = IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Beat selection from the next-cycle snapshot so the output register leads by nothing.
    always_comb begin
        beat_s = '0;
        case (state_s)
            SEND_STEP: beat_s = LINK_W'(snap_step_s >> (cnt_s * LINK_W));
            SEND_X:    beat_s = LINK_W'(snap_x_s >> (cnt_s * LINK_W));
            SEND_Y:    beat_s = LINK_W'(snap_y_s >> (cnt_s * LINK_W));
            default:   beat_s = '0;
        endcase
        last_s = (state_s == SEND_Y) && (cnt_s == CNT_W'(POS_BEATS - 1));
    end

    // State, snapshot and registered link outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            snap_step_r <= '0;
            snap_x_r    <= '0;
            snap_y_r    <= '0;
            valid_r     <= 1'b0;
            data_r      <= '0;
            last_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            snap_step_r <= snap_step_s;
            snap_x_r    <= snap_x_s;
            snap_y_r    <= snap_y_s;
            valid_r     <= (state_s != IDLE);
            data_r      <= beat_s;
            last_r      <= last_s;
        end
    end

endmodule

// File: rtl/boundary_link_tx.sv
// Boundary-exchange transmitter: first node goes left, last node goes right,
// on two independent framed channels.
module boundary_link_tx
    import boundary_link_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINK_W = 8,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_done,
    input  logic [STEP_W-1:0] step_idx,
    input  logic [DATA_W-1:0] first_x,
    input  logic [DATA_W-1:0] first_y,
    input  logic [DATA_W-1:0] last_x,
    input  logic [DATA_W-1:0] last_y,
    output logic              l_valid,
    output logic [LINK_W-1:0] l_data,
    output logic              l_last,
    input  logic              l_ready,
    output logic              r_valid,
    output logic [LINK_W-1:0] r_data,
    output logic              r_last,
    input  logic              r_ready,
    output logic              busy,
    output logic              overrun
);

    logic l_active_s, r_active_s, l_ignored_s, r_ignored_s;
    logic overrun_r;

    boundary_tx_channel #(.DATA_W(DATA_W), .LINK_W(LINK_W), .STEP_W(STEP_W)) u_left (
        .clk(clk), .reset(reset), .step_done(step_done), .step_idx(step_idx),
        .pos_x(first_x), .pos_y(first_y), .ready(l_ready),
        .valid(l_valid), .data(l_data), .last(l_last),
        .active(l_active_s), .ignored(l_ignored_s)
    );

    boundary_tx_channel #(.DATA_W(DATA_W), .LINK_W(LINK_W), .STEP_W(STEP_W)) u_right (
        .clk(clk), .reset(reset), .step_done(step_done), .step_idx(step_idx),
        .pos_x(last_x), .pos_y(last_y), .ready(r_ready),
        .valid(r_valid), .data(r_data), .last(r_last),
        .active(r_active_s), .ignored(r_ignored_s)
    );

    assign busy    = l_active_s | r_active_s;
    assign overrun = overrun_r;

    // Sticky record of any step_done that a busy channel had to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (l_ignored_s | r_ignored_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule
